// File: rtl/sdram_arb.sv
// sdram_arb: round-robin arbiter sharing one SDRAM controller between NPORTS masters.
// Latency: m_valid 1 cycle after s_valid, s_ready in the m_ready cycle, then 2 turnaround cycles.
// Backpressure: requests wait on s_valid until granted; `SDRAM_ARB_FIXED_PRIO_EN selects fixed priority.
module sdram_arb #(
  parameter int NPORTS = 2,
  parameter int AW     = 22
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    s_valid,
  input  logic [NPORTS*AW-1:0] s_addr,
  input  logic [NPORTS*32-1:0] s_din,
  input  logic [NPORTS*4-1:0]  s_wmask,
  output logic [NPORTS-1:0]    s_ready,
  output logic [31:0]          s_dout,
  output logic [AW-1:0]        m_addr,
  output logic [31:0]          m_din,
  output logic [3:0]           m_wmask,
  output logic                 m_valid,
  input  logic [31:0]          m_dout,
  input  logic                 m_ready,
  output logic                 busy,
  output logic [1:0]           grant_idx
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    last, last_nxt, grant_nxt, win;
  logic          any_vld;
  logic          m_valid_nxt;
  logic [AW-1:0] addr_nxt;
  logic [31:0]   din_nxt;
  logic [3:0]    wmask_nxt;

  // Highest-priority candidate is visited last so it overwrites the rest.
  always_comb begin
    win     = '0;
    any_vld = |s_valid;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (s_valid[i]) win = 2'(i);
    end
`else
    for (int k = NPORTS; k >= 1; k--) begin
      if (s_valid[(int'(last) + k) % NPORTS]) win = 2'((int'(last) + k) % NPORTS);
    end
`endif
  end

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    grant_nxt   = grant_idx;
    m_valid_nxt = m_valid;
    addr_nxt    = m_addr;
    din_nxt     = m_din;
    wmask_nxt   = m_wmask;
    case (state)
      IDLE: begin
        if (any_vld) begin
          state_nxt   = GRANT;
          m_valid_nxt = 1'b1;
          grant_nxt   = win;
          addr_nxt    = s_addr[int'(win)*AW +: AW];
          din_nxt     = s_din[int'(win)*32 +: 32];
          wmask_nxt   = s_wmask[int'(win)*4 +: 4];
        end
      end
      GRANT: begin
        if (m_ready) begin
          state_nxt   = DONE;
          m_valid_nxt = 1'b0;
          last_nxt    = grant_idx;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 2'(NPORTS - 1);
      grant_idx <= '0;
      m_valid   <= 1'b0;
      m_addr    <= '0;
      m_din     <= '0;
      m_wmask   <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      grant_idx <= grant_nxt;
      m_valid   <= m_valid_nxt;
      m_addr    <= addr_nxt;
      m_din     <= din_nxt;
      m_wmask   <= wmask_nxt;
    end
  end

  // m_ready outside GRANT is spurious and never reaches a port.
  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NPORTS; i++) begin
      s_ready[i] = m_ready && (state == GRANT) && (grant_idx == 2'(i));
    end
  end

  assign s_dout = m_dout;
  assign busy   = (state == GRANT) || (state == DONE);

endmodule
